// File: rtl/e1000_axi_pkg.sv
// Shared AXI4 encodings for the e1000 local-side fabric, plus the state
// encoding of the local RAM responder.
//   AXI_RESP_*  : BRESP/RRESP codes
//   AXI_BURST_* : AWBURST/ARBURST codes
//   AXI_SIZE_4B : the only beat size the 32-bit local RAM accepts
package e1000_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WDATA = 2'd1,
        S_WRESP = 2'd2,
        S_RDATA = 2'd3
    } ram_state_t;

endpackage

// File: rtl/local_ram_1rw.sv
// Single-port RAM, WORDS x 32 bits, four byte enables, registered read.
//   aclk  : clock
//   en    : access enable (read data register loads only when set)
//   we    : per-byte write enables, applied when en is set
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid one cycle after an enabled access
// Contents are not reset.
module local_ram_1rw #(
    parameter int WORDS = 4096,
    parameter int AW    = 12
) (
    input  logic          aclk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge aclk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/axi_local_ram.sv
// AXI4 responder in front of the on-chip local packet/descriptor RAM.
// One burst (read or write) at a time; reads and writes share the single RAM
// port. 32-bit data, byte-strobed writes, IDs echoed on B and R.
//   aclk, aresetn               : clock, asynchronous active-low reset
//   s_aw*                       : write address channel (addr[1:0] ignored)
//   s_w*                        : write data channel (s_wid ignored)
//   s_b*                        : write response channel
//   s_ar*                       : read address channel (addr[1:0] ignored)
//   s_r*                        : read data channel
// Errors (SLVERR): beat size other than 4 bytes, word index >= MEM_WORDS,
// and for writes a WLAST that does not land on beat len+1.
module axi_local_ram
    import e1000_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_WORDS  = 4096,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic [ID_WIDTH-1:0]   s_awid,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic [7:0]            s_awlen,
    input  logic [2:0]            s_awsize,
    input  logic [1:0]            s_awburst,
    input  logic                  s_awvalid,
    output logic                  s_awready,

    input  logic [ID_WIDTH-1:0]   s_wid,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    input  logic                  s_wlast,
    input  logic                  s_wvalid,
    output logic                  s_wready,

    output logic [ID_WIDTH-1:0]   s_bid,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,

    input  logic [ID_WIDTH-1:0]   s_arid,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [7:0]            s_arlen,
    input  logic [2:0]            s_arsize,
    input  logic [1:0]            s_arburst,
    input  logic                  s_arvalid,
    output logic                  s_arready,

    output logic [ID_WIDTH-1:0]   s_rid,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic                  s_rvalid,
    input  logic                  s_rready
);

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int RAM_AW = $clog2(MEM_WORDS);

    // FIXED holds the word index; INCR and WRAP both step it (WRAP is treated
    // as INCR). The index wraps naturally at its own width.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                  input logic [1:0]       burst);
        return (burst == AXI_BURST_FIXED) ? idx : idx + 1'b1;
    endfunction

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return 32'(idx) < 32'(MEM_WORDS);
    endfunction

    ram_state_t state_q, state_d;

    // Control state (reset)
    logic            prio_write;
    logic            werr;
    logic            size_bad;
    logic [8:0]      beat_cnt;
    logic            vld_p1;
    logic [1:0]      fifo_cnt;
    logic            wptr, rptr;

    // Burst context and datapath (not reset)
    logic [IDX_W-1:0] idx;
    logic [7:0]       len;
    logic [1:0]       burst;
    logic             err_p1, last_p1;
    logic [31:0]      ram_rdata_p1;
    logic [31:0]      fifo_data [2];
    logic [1:0]       fifo_resp [2];
    logic             fifo_last [2];

    logic grant_w, grant_r;
    logic aw_fire, ar_fire, w_fire, pop, push;
    logic w_in_range, w_beat_ok, w_beat_err, w_last_expected;
    logic rd_issue, rd_beat_err, rd_last;
    logic [3:0] ram_we;

    logic unused_inputs;
    assign unused_inputs = ^{s_wid, s_awaddr[1:0], s_araddr[1:0]};

    // Round-robin: on a tie, the channel not served last wins.
    assign grant_w   = s_awvalid && (!s_arvalid || prio_write);
    assign grant_r   = s_arvalid && !grant_w;
    assign s_awready = (state_q == S_IDLE) && grant_w;
    assign s_arready = (state_q == S_IDLE) && grant_r;
    assign aw_fire   = s_awvalid && s_awready;
    assign ar_fire   = s_arvalid && s_arready;

    assign s_wready        = (state_q == S_WDATA);
    assign w_fire          = s_wvalid && s_wready;
    assign w_in_range      = in_range(idx);
    assign w_last_expected = (beat_cnt == {1'b0, len});
    // Beats past len+1 are never written; beat_cnt saturates at len+1.
    assign w_beat_ok       = !size_bad && w_in_range && (beat_cnt <= {1'b0, len});
    assign w_beat_err      = size_bad || !w_in_range || (s_wlast != w_last_expected);
    assign ram_we          = (w_fire && w_beat_ok) ? s_wstrb : 4'b0000;

    // A read may be issued only if it will find a buffer slot when it lands:
    // entries held + reads in flight must stay below 2 after this cycle's pop.
    assign pop         = s_rvalid && s_rready;
    assign push        = vld_p1;
    assign rd_issue    = (state_q == S_RDATA) && (beat_cnt <= {1'b0, len}) &&
                         ((3'(fifo_cnt) + 3'(vld_p1)) < (3'd2 + 3'(pop)));
    assign rd_beat_err = size_bad || !in_range(idx);
    assign rd_last     = (beat_cnt == {1'b0, len});

    local_ram_1rw #(
        .WORDS (MEM_WORDS),
        .AW    (RAM_AW)
    ) u_ram (
        .aclk  (aclk),
        .en    (w_fire || rd_issue),
        .we    (ram_we),
        .addr  (idx[RAM_AW-1:0]),
        .wdata (s_wdata),
        .rdata (ram_rdata_p1)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (aw_fire) begin
                    state_d = S_WDATA;
                end else if (ar_fire) begin
                    state_d = S_RDATA;
                end
            end
            S_WDATA: begin
                if (w_fire && s_wlast) begin
                    state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                if (s_bvalid && s_bready) begin
                    state_d = S_IDLE;
                end
            end
            S_RDATA: begin
                if (pop && s_rlast) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            prio_write <= 1'b1;
            werr       <= 1'b0;
            size_bad   <= 1'b0;
            beat_cnt   <= '0;
            s_bvalid   <= 1'b0;
            s_bresp    <= AXI_RESP_OKAY;
            s_bid      <= '0;
            s_rid      <= '0;
            vld_p1     <= 1'b0;
            fifo_cnt   <= 2'd0;
            wptr       <= 1'b0;
            rptr       <= 1'b0;
        end else begin
            state_q <= state_d;

            if (aw_fire) begin
                prio_write <= 1'b0;
                s_bid      <= s_awid;
                werr       <= 1'b0;
                beat_cnt   <= '0;
                size_bad   <= (s_awsize != AXI_SIZE_4B);
            end
            if (ar_fire) begin
                prio_write <= 1'b1;
                s_rid      <= s_arid;
                beat_cnt   <= '0;
                size_bad   <= (s_arsize != AXI_SIZE_4B);
            end

            if (w_fire) begin
                werr <= werr || w_beat_err;
                if (beat_cnt <= {1'b0, len}) begin
                    beat_cnt <= beat_cnt + 9'd1;
                end
            end
            if (w_fire && s_wlast) begin
                s_bvalid <= 1'b1;
                s_bresp  <= (werr || w_beat_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end else if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
            end

            if (rd_issue) begin
                beat_cnt <= beat_cnt + 9'd1;
            end
            vld_p1 <= rd_issue;

            if (push) begin
                wptr <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
        end
    end

    // Stage 0 -> 1: RAM access issued, beat attributes follow the read
    always_ff @(posedge aclk) begin
        if (aw_fire) begin
            idx   <= s_awaddr[ADDR_WIDTH-1:2];
            len   <= s_awlen;
            burst <= s_awburst;
        end else if (ar_fire) begin
            idx   <= s_araddr[ADDR_WIDTH-1:2];
            len   <= s_arlen;
            burst <= s_arburst;
        end else if (w_fire || rd_issue) begin
            idx <= next_idx(idx, burst);
        end
        if (rd_issue) begin
            err_p1  <= rd_beat_err;
            last_p1 <= rd_last;
        end
    // Stage 1 -> 2: RAM data lands in the output buffer
        if (push) begin
            fifo_data[wptr] <= err_p1 ? 32'h0 : ram_rdata_p1;
            fifo_resp[wptr] <= err_p1 ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            fifo_last[wptr] <= last_p1;
        end
    end

    // Head of the buffer drives R; it only changes on a pop, so the beat is
    // stable while stalled.
    assign s_rvalid = (fifo_cnt != 2'd0);
    assign s_rdata  = fifo_data[rptr];
    assign s_rresp  = s_rvalid ? fifo_resp[rptr] : AXI_RESP_OKAY;
    assign s_rlast  = s_rvalid && fifo_last[rptr];

endmodule

// File: tb/tb_axi_local_ram.sv
// Directed bench for axi_local_ram: write/read bursts, strobes, arbitration,
// stalled reads, range/size/WLAST errors and reset mid-burst.
module tb_axi_local_ram;

    logic        aclk;
    logic        aresetn;
    logic [3:0]  s_awid, s_wid, s_bid, s_arid, s_rid;
    logic [15:0] s_awaddr, s_araddr;
    logic [7:0]  s_awlen, s_arlen;
    logic [2:0]  s_awsize, s_arsize;
    logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
    logic        s_bvalid, s_bready, s_arvalid, s_arready;
    logic        s_rlast, s_rvalid, s_rready;
    logic [31:0] s_wdata, s_rdata;
    logic [3:0]  s_wstrb;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] got_data [16];
    logic [1:0]  got_resp [16];
    logic        got_last [16];
    logic [3:0]  got_id   [16];
    int          got_cyc  [16];

    axi_local_ram dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst;
        s_awvalid = 1'b1;
        #1;
        n = 0;
        while (!s_awready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("aw_timeout", 32'(n), 32'd0);
        tick();
        s_awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
        s_arvalid = 1'b1;
        #1;
        n = 0;
        while (!s_arready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("ar_timeout", 32'(n), 32'd0);
        tick();
        s_arvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n;
        s_wdata = data; s_wstrb = strb; s_wlast = last; s_wvalid = 1'b1;
        #1;
        n = 0;
        while (!s_wready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("w_timeout", 32'(n), 32'd0);
        tick();
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
    endtask

    task automatic b_check(input logic [3:0] exp_id, input logic [1:0] exp_resp);
        int n;
        s_bready = 1'b1;
        #1;
        n = 0;
        while (!s_bvalid && n < 50) begin
            tick();
            n++;
        end
        check("b_valid", 32'(s_bvalid), 32'd1);
        check("b_id", 32'(s_bid), 32'(exp_id));
        check("b_resp", 32'(s_bresp), 32'(exp_resp));
        tick();
        s_bready = 1'b0;
        check("b_valid_drop", 32'(s_bvalid), 32'd0);
    endtask

    // mode 0: rready held high; mode 1: rready pattern 1,0,0,1,0,0...
    task automatic r_collect(input int n, input int mode);
        int k, cyc;
        logic stalled;
        logic [31:0] pd;
        logic [1:0] pr;
        logic pl;
        k = 0; cyc = 0; stalled = 1'b0; pd = '0; pr = '0; pl = 1'b0;
        while (k < n && cyc < 400) begin
            s_rready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (stalled) begin
                check("r_stall_valid", 32'(s_rvalid), 32'd1);
                check("r_stall_data", s_rdata, pd);
                check("r_stall_resp", 32'(s_rresp), 32'(pr));
                check("r_stall_last", 32'(s_rlast), 32'(pl));
            end
            stalled = 1'b0;
            if (s_rvalid) begin
                if (s_rready) begin
                    got_data[k] = s_rdata;
                    got_resp[k] = s_rresp;
                    got_last[k] = s_rlast;
                    got_id[k]   = s_rid;
                    got_cyc[k]  = cyc;
                    k++;
                end else begin
                    stalled = 1'b1;
                    pd = s_rdata; pr = s_rresp; pl = s_rlast;
                end
            end
            tick();
            cyc++;
        end
        s_rready = 1'b0;
        check("r_beat_count", 32'(k), 32'(n));
        check("r_no_extra", 32'(s_rvalid), 32'd0);
    endtask

    initial begin
        aresetn = 1'b0;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = 1'b0;
        s_wid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0;
        s_bready = 1'b0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arvalid = 1'b0;
        s_rready = 1'b0;
        tick(); tick();

        // Reset values
        check("rst_awready", 32'(s_awready), 32'd0);
        check("rst_arready", 32'(s_arready), 32'd0);
        check("rst_wready", 32'(s_wready), 32'd0);
        check("rst_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_rlast", 32'(s_rlast), 32'd0);
        check("rst_bid", 32'(s_bid), 32'd0);
        check("rst_rid", 32'(s_rid), 32'd0);
        check("rst_bresp", 32'(s_bresp), 32'd0);
        check("rst_rresp", 32'(s_rresp), 32'd0);
        aresetn = 1'b1;
        tick(); tick();

        // Test 3: simultaneous AW/AR from reset -> write wins, next tie -> read wins
        s_awid = 4'd3; s_awaddr = 16'h0300; s_awlen = 8'd0; s_awsize = 3'b010; s_awburst = 2'b01;
        s_arid = 4'd5; s_araddr = 16'h0300; s_arlen = 8'd0; s_arsize = 3'b010; s_arburst = 2'b01;
        s_awvalid = 1'b1; s_arvalid = 1'b1;
        #1;
        check("tie1_awready", 32'(s_awready), 32'd1);
        check("tie1_arready", 32'(s_arready), 32'd0);
        tick();
        s_awvalid = 1'b0;
        w_beat(32'h12345678, 4'hF, 1'b1);
        b_check(4'd3, 2'b00);
        s_awid = 4'd6; s_awaddr = 16'h0304; s_awvalid = 1'b1;
        #1;
        check("tie2_arready", 32'(s_arready), 32'd1);
        check("tie2_awready", 32'(s_awready), 32'd0);
        tick();
        s_arvalid = 1'b0;
        r_collect(1, 0);
        check("tie2_rdata", got_data[0], 32'h12345678);
        check("tie2_rid", 32'(got_id[0]), 32'd5);
        check("tie2_rlast", 32'(got_last[0]), 32'd1);
        check("tie3_awready", 32'(s_awready), 32'd1);
        tick();
        s_awvalid = 1'b0;
        w_beat(32'h9ABCDEF0, 4'hF, 1'b1);
        b_check(4'd6, 2'b00);

        // Test 1: 4-beat INCR write then read with latency check
        aw_send(4'd1, 16'h0100, 8'd3, 3'b010, 2'b01);
        w_beat(32'h11111111, 4'hF, 1'b0);
        w_beat(32'h22222222, 4'hF, 1'b0);
        w_beat(32'h33333333, 4'hF, 1'b0);
        w_beat(32'h44444444, 4'hF, 1'b1);
        b_check(4'd1, 2'b00);
        ar_send(4'd2, 16'h0100, 8'd3, 3'b010, 2'b01);
        check("t1_rvalid_c0", 32'(s_rvalid), 32'd0);
        tick();
        check("t1_rvalid_c1", 32'(s_rvalid), 32'd0);
        tick();
        check("t1_rvalid_c2", 32'(s_rvalid), 32'd1);
        r_collect(4, 0);
        check("t1_d0", got_data[0], 32'h11111111);
        check("t1_d1", got_data[1], 32'h22222222);
        check("t1_d2", got_data[2], 32'h33333333);
        check("t1_d3", got_data[3], 32'h44444444);
        check("t1_last2", 32'(got_last[2]), 32'd0);
        check("t1_last3", 32'(got_last[3]), 32'd1);
        check("t1_rid", 32'(got_id[3]), 32'd2);
        check("t1_rresp", 32'(got_resp[0]), 32'd0);

        // Test 2: partial strobe over zero pre-fill
        aw_send(4'd2, 16'h0200, 8'd0, 3'b010, 2'b01);
        w_beat(32'h00000000, 4'hF, 1'b1);
        b_check(4'd2, 2'b00);
        aw_send(4'd4, 16'h0200, 8'd0, 3'b010, 2'b01);
        w_beat(32'hAABBCCDD, 4'b0110, 1'b1);
        b_check(4'd4, 2'b00);
        ar_send(4'd7, 16'h0200, 8'd0, 3'b010, 2'b01);
        r_collect(1, 0);
        check("t2_strobe", got_data[0], 32'h00BBCC00);

        // Test 4: 16-beat read, stalled and then streaming
        aw_send(4'd9, 16'h0400, 8'd15, 3'b010, 2'b01);
        for (int i = 0; i < 16; i++) w_beat(32'h40000000 | 32'(i), 4'hF, i == 15);
        b_check(4'd9, 2'b00);
        ar_send(4'd8, 16'h0400, 8'd15, 3'b010, 2'b01);
        r_collect(16, 1);
        for (int i = 0; i < 16; i++) begin
            check("t4_stall_data", got_data[i], 32'h40000000 | 32'(i));
            check("t4_stall_last", 32'(got_last[i]), 32'(i == 15));
        end
        ar_send(4'd8, 16'h0400, 8'd15, 3'b010, 2'b01);
        r_collect(16, 0);
        for (int i = 0; i < 16; i++) check("t4_stream_data", got_data[i], 32'h40000000 | 32'(i));
        check("t4_stream_span", 32'(got_cyc[15] - got_cyc[0]), 32'd15);

        // Test 5: range, WLAST and size errors
        aw_send(4'd8, 16'h0000, 8'd0, 3'b010, 2'b01);
        w_beat(32'hCAFEF00D, 4'hF, 1'b1);
        b_check(4'd8, 2'b00);
        aw_send(4'd9, 16'h3FFC, 8'd1, 3'b010, 2'b01);
        w_beat(32'hDEADBEEF, 4'hF, 1'b0);
        w_beat(32'h0BADC0DE, 4'hF, 1'b1);
        b_check(4'd9, 2'b10);
        ar_send(4'd10, 16'h3FFC, 8'd1, 3'b010, 2'b01);
        r_collect(2, 0);
        check("t5_edge_d0", got_data[0], 32'hDEADBEEF);
        check("t5_edge_r0", 32'(got_resp[0]), 32'd0);
        check("t5_oor_d1", got_data[1], 32'h00000000);
        check("t5_oor_r1", 32'(got_resp[1]), 32'd2);
        check("t5_oor_last", 32'(got_last[1]), 32'd1);
        ar_send(4'd11, 16'h0000, 8'd0, 3'b010, 2'b01);
        r_collect(1, 0);
        check("t5_word0_intact", got_data[0], 32'hCAFEF00D);
        aw_send(4'd11, 16'h0600, 8'd3, 3'b010, 2'b01);
        w_beat(32'h66660000, 4'hF, 1'b0);
        w_beat(32'h66660001, 4'hF, 1'b1);
        b_check(4'd11, 2'b10);
        ar_send(4'd12, 16'h0100, 8'd0, 3'b001, 2'b01);
        r_collect(1, 0);
        check("t5_size_data", got_data[0], 32'h00000000);
        check("t5_size_resp", 32'(got_resp[0]), 32'd2);
        check("t5_size_rid", 32'(got_id[0]), 32'd12);

        // Test 6: reset in the middle of a write burst
        aw_send(4'd7, 16'h0500, 8'd3, 3'b010, 2'b01);
        w_beat(32'h55550000, 4'hF, 1'b0);
        w_beat(32'h55550001, 4'hF, 1'b0);
        aresetn = 1'b0;
        #1;
        check("t6_wready", 32'(s_wready), 32'd0);
        check("t6_awready", 32'(s_awready), 32'd0);
        check("t6_arready", 32'(s_arready), 32'd0);
        check("t6_bvalid", 32'(s_bvalid), 32'd0);
        check("t6_rvalid", 32'(s_rvalid), 32'd0);
        check("t6_bid", 32'(s_bid), 32'd0);
        tick();
        aresetn = 1'b1;
        begin
            int seen_b;
            seen_b = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (s_bvalid) seen_b++;
            end
            check("t6_no_bvalid", 32'(seen_b), 32'd0);
        end
        ar_send(4'd13, 16'h0500, 8'd1, 3'b010, 2'b01);
        r_collect(2, 0);
        check("t6_keep_d0", got_data[0], 32'h55550000);
        check("t6_keep_d1", got_data[1], 32'h55550001);
        check("t6_rid", 32'(got_id[1]), 32'd13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
